// File: rtl/sha3_pkg.sv
// Shared SHA3 types, digest modes and beat-count helper for the tx/rx slice.
package sha3_pkg;

  typedef logic [4:0][4:0][63:0] sha3_state_t;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  localparam int unsigned DIGEST_LANES = 8;
  localparam int unsigned FLAT_W       = 64 * DIGEST_LANES;

  // Number of DATA_W-bit beats needed to carry the digest for a mode.
  function automatic int unsigned nwords(input sha3_mode_e mode, input int unsigned data_w);
    int unsigned bits;
    case (mode)
      SHA3_224: bits = 224;
      SHA3_256: bits = 256;
      SHA3_384: bits = 384;
      default:  bits = 512;
    endcase
    return bits / data_w;
  endfunction

endpackage

// File: rtl/sha3_state_flatten.sv
// Flattens the first eight Keccak lanes (lane i = x+5y) into a little-endian
// 512-bit vector, lane i at bits [64i+63:64i].
module sha3_state_flatten
  import sha3_pkg::*;
(
  input  sha3_state_t        state,
  output logic [FLAT_W-1:0]  flat
);

  for (genvar i = 0; i < DIGEST_LANES; i++) begin : g_lane
    assign flat[64*i +: 64] = state[i/5][i%5];
  end

  // Lanes 8..24 never reach a digest.
  logic unused_lanes;
  assign unused_lanes = ^{state[4], state[3], state[2], state[1][4:3]};

endmodule

// File: rtl/sha3_axis_digest_tx.sv
// AXI-Stream digest transmitter: loads a finished Keccak state and streams the
// selected digest length as DATA_W-bit little-endian beats with TLAST.
module sha3_axis_digest_tx
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned USER_W = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                s_valid,
  output logic                s_ready,
  input  sha3_state_t         s_state,
  input  logic [1:0]          s_mode,
  input  logic [ID_W-1:0]     s_id,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tlast,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic [ID_W-1:0]     m_tid,
  output logic [USER_W-1:0]   m_tuser
);

  tx_state_e         state, state_nxt;
  logic [FLAT_W-1:0] flat;
  logic [FLAT_W-1:0] shreg;
  logic [4:0]        cnt;
  logic [4:0]        last;
  logic              load;
  logic              beat;
  logic              is_last;

  sha3_state_flatten u_flatten (
    .state (s_state),
    .flat  (flat)
  );

  assign load    = s_valid && s_ready;
  assign beat    = m_tvalid && m_tready;
  assign is_last = (cnt == last);

  assign m_tdata = shreg[DATA_W-1:0];
  assign m_tlast = m_tvalid && is_last;
  assign m_tkeep = {(DATA_W/8){m_tvalid}};

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshake outputs; m_tvalid depends on state only.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_tvalid  = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = SEND;
      end
      SEND: begin
        m_tvalid = 1'b1;
        if (m_tready && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, beat counter and latched sideband; the counter holds on
  // the final beat so it never wraps.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      shreg   <= '0;
      cnt     <= '0;
      last    <= '0;
      m_tid   <= '0;
      m_tuser <= '0;
    end else if (load) begin
      shreg   <= flat;
      cnt     <= '0;
      last    <= 5'(nwords(sha3_mode_e'(s_mode), DATA_W) - 1);
      m_tid   <= s_id;
      m_tuser <= USER_W'(s_mode);
    end else if (beat) begin
      shreg <= shreg >> DATA_W;
      if (!is_last) cnt <= cnt + 5'd1;
    end
  end

endmodule
